restoring_divider_32: RTL

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, the inverse counterpart of the team's 32x32 Booth multiplier in the M-extension execute path. It is a registered radix-2 restoring divider: one quotient bit per cycle, 32 iterations. It uses the same start/ready/valid handshake as the multiplier, so the EX-stage M-unit controller drives both blocks identically.

---
 rtl/restoring_divider_32.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/restoring_divider_32.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; start/ready/valid handshake shared with the multiplier.
module restoring_divider_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    input  logic        ready,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rsel_q, rsel_d;
    logic        neg_q, neg_d;
    logic        sa_q, sa_d;

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] sh;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_it;
    logic [31:0] quo_it;

    // op[0] = 0 selects the signed variants (DIV, REM)
    assign sgn   = ~op[0];
    assign a_neg = sgn & a[31];
    assign b_neg = sgn & b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;

    // Dividend bits stream out of quo_q MSB-first while quotient bits enter at the LSB
    assign sh     = {rem_q, quo_q[31]};
    assign diff   = sh - {1'b0, dvs_q};
    assign ge     = ~diff[32];
    assign rem_it = ge ? diff[31:0] : sh[31:0];
    assign quo_it = {quo_q[30:0], ge};

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        rsel_d  = rsel_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rsel_d = op[1];
                    neg_d  = a_neg ^ b_neg;
                    sa_d   = a_neg;
                    dvs_d  = b_mag;
                    quo_d  = a_mag;
                    rem_d  = 32'd0;
                    cnt_d  = 5'd0;
                    if (b == 32'd0) begin
                        state_d = DONE;
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = a;
                    end else if (sgn && a == 32'h8000_0000 &&
                                 b == 32'hFFFF_FFFF) begin
                        state_d = DONE;
                        quo_d   = 32'h8000_0000;
                        rem_d   = 32'd0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = quo_it;
                rem_d = rem_it;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    quo_d   = neg_q ? (32'd0 - quo_it) : quo_it;
                    rem_d   = sa_q ? (32'd0 - rem_it) : rem_it;
                end
            end
            DONE: begin
                if (ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 5'd0;
            rsel_q  <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign valid  = (state_q == DONE);
    assign done   = valid & ready;
    assign result = valid ? (rsel_q ? rem_q : quo_q) : 32'd0;

endmodule
